nf_router_dec: RTL and testbench
================================

Name: nf_router_dec

Overview:
Master-side request decoder/demultiplexer for the lw/sw bus router. It owns the request direction, master→slave.
- Decodes the master address against a fixed address map.
- Forwards the request to exactly one slave and waits for that slave's acknowledge, with a timeout.
- Drives the registered one-hot `slave_sel` consumed by the read-data mux on the return path.

Parameters:
- `Slave_n`, default `` `SLAVE_NUMBER `` (4): number of slave ports.
- `Tmo_w`, default 8: timeout counter width. Timeout limit is 2^`Tmo_w`-1 cycles.

Ports:
- `clk` in 1: system clock, rising edge.
- `resetn` in 1: asynchronous active-low reset.
- `req_m` in 1: master request; held until `req_ack_m`.
- `addr_m` in 32: master address.
- `we_m` in 1: master write enable (1 = sw, 0 = lw).
- `wd_m` in 32: master write data.
- `req_ack_m` out 1: one-cycle completion pulse to master.
- `err_m` out 1: error qualifier, valid only with `req_ack_m` (unmapped address or timeout).
- `addr_s` out 32: registered address, broadcast to all slaves.
- `we_s` out 1: registered write enable, broadcast.
- `wd_s` out 32: registered write data, broadcast.
- `req_s` out `Slave_n`: one-hot per-slave request.
- `req_ack_s` in `Slave_n`: per-slave acknowledge.
- `slave_sel` out `Slave_n`: registered one-hot select of the last accepted slave, to the read mux.

Behaviour:
- Reset (async, `resetn`=0): FSM=IDLE. All outputs 0, including `slave_sel`=0 and the timeout counter. Reset mid-transaction aborts it silently; no ack is issued.
- Decode: slave i hits when (`addr_m` & `MASK`[i]) == `BASE`[i]. The lowest matching index wins. At most one bit is ever set in `req_s`/`slave_sel`.
- Default map (mask 0xFFFF_0000 for all slaves):
  - slave0 RAM 0x0000_0000
  - slave1 GPIO 0x0001_0000
  - slave2 PWM 0x0002_0000
  - slave3 UART 0x0003_0000
- State IDLE: `req_s`=0.
  - On `req_m`=1 with a hit on k: latch `addr`/`we`/`wd`, set `slave_sel`=one-hot(k), `req_s`[k]=1 next cycle → WAIT. Counter cleared.
  - On `req_m`=1 with a miss: → RESP with err=1. No slave request; `slave_sel` unchanged.
- State WAIT: `req_s`[k] held high and `addr_s`/`we_s`/`wd_s` stable. Counter increments each cycle.
  - `req_ack_s`[k]=1 sampled → `req_s`=0 next cycle → RESP, err=0.
  - Counter == 2^`Tmo_w`-1 without ack → `req_s`=0 → RESP, err=1.
  - If the ack arrives in the same cycle as the limit, the ack wins (err=0).
  - `req_ack_s` bits for non-selected slaves are ignored.
- State RESP: `req_ack_m`=1 and `err_m`=err for exactly one cycle → IDLE.
- Back-to-back: `req_m` still high in the IDLE cycle after RESP is a new transaction.
- Latency: a hit acked in its first WAIT cycle gives `req_m`@c0, `req_s`@c1, `req_ack_m`@c2. A miss gives `req_ack_m`@c1.
- `slave_sel` persists after RESP until the next accepted hit, so the read mux keeps returning the last slave's data.
- Inputs `addr_m`/`we_m`/`wd_m` are sampled only in IDLE; changes during WAIT have no effect.

Decomposition:
- `nf_router_pkg` holds:
  - `SLAVE_NUMBER`
  - `BASE`/`MASK` arrays, typed `logic [SLAVE_NUMBER-1:0][31:0]`
  - FSM enum `router_st_t` {`IDLE`, `WAIT`, `RESP`}
- One sub-module: `nf_addr_dec`, combinational address→one-hot hit plus miss flag, with lowest-index priority. The FSM, counter and registers stay in `nf_router_dec`.

Test Plan:
- Reset, then lw `addr_m`=0x0001_0004, `req_ack_s`[1] high one cycle after `req_s`[1] rises:
  - `addr_s`=0x0001_0004, `we_s`=0, `req_s`=0010 for 2 cycles, `slave_sel`=0010
  - `req_ack_m` pulse 1 cycle with `err_m`=0, 3 cycles after `req_m`.
- sw `addr_m`=0x0003_0000, `wd_m`=0xDEAD_BEEF, immediate ack:
  - `we_s`=1, `wd_s`=0xDEAD_BEEF, `req_s`=1000, `req_ack_m` at c2.
- Unmapped `addr_m`=0x0009_0000 after a slave1 access:
  - `req_s` stays 0, `req_ack_m`=1 and `err_m`=1 at c1, `slave_sel` remains 0010.
- Slave2 never acks, `Tmo_w`=4:
  - `req_s`=0100 for 15 cycles then drops.
  - `req_ack_m`+`err_m` pulse follows. Ack at exactly cycle 15 in a second run gives `err_m`=0.
- Back-to-back: `req_m` held high across two transactions (slave0 then slave3):
  - second `req_s`=1000 starts 1 cycle after the first `req_ack_m`, and `slave_sel` switches 0001→1000.
- `resetn` pulled low during WAIT: `req_s`, `slave_sel`, `req_ack_m` = 0 asynchronously, and no ack is produced after release.

Source files
------------

// File: rtl/nf_router_pkg.sv
// Shared definitions for the lw/sw bus router: slave count, address map, FSM states.
`ifndef SLAVE_NUMBER
`define SLAVE_NUMBER 4
`endif

package nf_router_pkg;

  localparam int SLAVE_NUMBER = `SLAVE_NUMBER;

  // Address map, index 0 on the right: RAM, GPIO, PWM, UART.
  localparam logic [SLAVE_NUMBER-1:0][31:0] BASE = {
    32'h0003_0000,
    32'h0002_0000,
    32'h0001_0000,
    32'h0000_0000
  };

  localparam logic [SLAVE_NUMBER-1:0][31:0] MASK = {
    32'hFFFF_0000,
    32'hFFFF_0000,
    32'hFFFF_0000,
    32'hFFFF_0000
  };

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } router_st_t;

endpackage

// File: rtl/nf_addr_dec.sv
// Combinational address decoder: one-hot hit with lowest-index priority plus a miss flag.
module nf_addr_dec
  import nf_router_pkg::*;
#(
  parameter int Slave_n = SLAVE_NUMBER
) (
  input  logic [31:0]        addr,
  output logic [Slave_n-1:0] hit,
  output logic               miss
);

  logic [Slave_n-1:0] match;

  // Ports beyond the address map never match.
  for (genvar g = 0; g < Slave_n; g++) begin : g_match
    if (g < SLAVE_NUMBER) begin : g_map
      assign match[g] = ((addr & MASK[g]) == BASE[g]);
    end else begin : g_none
      assign match[g] = 1'b0;
    end
  end

  // Keep only the lowest matching index so overlapping map entries stay one-hot.
  always_comb begin
    logic found;
    hit   = '0;
    found = 1'b0;
    for (int i = 0; i < Slave_n; i++) begin
      if (match[i] && !found) begin
        hit[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

  assign miss = ~|match;

endmodule

// File: rtl/nf_router_dec.sv
// Master-side request decoder/demux: routes one master request to one slave,
// waits for its acknowledge with a timeout, and holds the read-mux select.
//
//   state | meaning
//   IDLE  | no transaction; decode req_m and either launch to a slave or fail
//   WAIT  | req_s held on the selected slave; counting toward timeout
//   RESP  | one-cycle req_ack_m with err_m to the master
module nf_router_dec
  import nf_router_pkg::*;
#(
  parameter int Slave_n = SLAVE_NUMBER,
  parameter int Tmo_w   = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_m,
  input  logic [31:0]        addr_m,
  input  logic               we_m,
  input  logic [31:0]        wd_m,
  output logic               req_ack_m,
  output logic               err_m,
  output logic [31:0]        addr_s,
  output logic               we_s,
  output logic [31:0]        wd_s,
  output logic [Slave_n-1:0] req_s,
  input  logic [Slave_n-1:0] req_ack_s,
  output logic [Slave_n-1:0] slave_sel
);

  // The counter starts at 0 on the first WAIT cycle; reaching 2^Tmo_w-1 on the
  // next increment ends the wait, which leaves req_s high for 2^Tmo_w-1 cycles.
  localparam logic [Tmo_w-1:0] CntLast = Tmo_w'((1 << Tmo_w) - 2);

  router_st_t         state;
  logic [Tmo_w-1:0]   cnt;
  logic [Slave_n-1:0] hit;
  logic               miss;
  logic               ack_sel;

  nf_addr_dec #(
    .Slave_n (Slave_n)
  ) u_addr_dec (
    .addr (addr_m),
    .hit  (hit),
    .miss (miss)
  );

  // req_s is one-hot on the selected slave, so this masks off other slaves' acks.
  assign ack_sel = |(req_ack_s & req_s);

  // Request FSM with registered slave-side and master-side outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ack_m <= 1'b0;
      err_m     <= 1'b0;
      addr_s    <= '0;
      we_s      <= 1'b0;
      wd_s      <= '0;
      req_s     <= '0;
      slave_sel <= '0;
    end else begin
      case (state)
        IDLE: begin
          req_ack_m <= 1'b0;
          err_m     <= 1'b0;
          if (req_m) begin
            if (miss) begin
              // Unmapped: answer straight away, leave slave_sel on the last slave.
              req_ack_m <= 1'b1;
              err_m     <= 1'b1;
              state     <= RESP;
            end else begin
              addr_s    <= addr_m;
              we_s      <= we_m;
              wd_s      <= wd_m;
              req_s     <= hit;
              slave_sel <= hit;
              cnt       <= '0;
              state     <= WAIT;
            end
          end
        end
        WAIT: begin
          if (ack_sel) begin
            req_s     <= '0;
            req_ack_m <= 1'b1;
            err_m     <= 1'b0;
            state     <= RESP;
          end else if (cnt == CntLast) begin
            req_s     <= '0;
            req_ack_m <= 1'b1;
            err_m     <= 1'b1;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          req_ack_m <= 1'b0;
          err_m     <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          req_s     <= '0;
          req_ack_m <= 1'b0;
          err_m     <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nf_router_dec.sv
// Directed bench for nf_router_dec with a 4-bit timeout counter.
module tb_nf_router_dec;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_m;
  logic [31:0] addr_m;
  logic        we_m;
  logic [31:0] wd_m;
  logic        req_ack_m;
  logic        err_m;
  logic [31:0] addr_s;
  logic        we_s;
  logic [31:0] wd_s;
  logic [3:0]  req_s;
  logic [3:0]  req_ack_s;
  logic [3:0]  slave_sel;

  int checks = 0;
  int errors = 0;

  nf_router_dec #(
    .Slave_n (4),
    .Tmo_w   (4)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .req_m     (req_m),
    .addr_m    (addr_m),
    .we_m      (we_m),
    .wd_m      (wd_m),
    .req_ack_m (req_ack_m),
    .err_m     (err_m),
    .addr_s    (addr_s),
    .we_s      (we_s),
    .wd_s      (wd_s),
    .req_s     (req_s),
    .req_ack_s (req_ack_s),
    .slave_sel (slave_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    resetn    = 1'b0;
    req_m     = 1'b0;
    addr_m    = '0;
    we_m      = 1'b0;
    wd_m      = '0;
    req_ack_s = '0;

    // Reset state
    tick();
    tick();
    chk("rst_req_s", 32'(req_s), 32'h0);
    chk("rst_sel", 32'(slave_sel), 32'h0);
    chk("rst_ack_m", 32'(req_ack_m), 32'h0);
    chk("rst_err_m", 32'(err_m), 32'h0);
    chk("rst_addr_s", addr_s, 32'h0);
    chk("rst_wd_s", wd_s, 32'h0);
    resetn = 1'b1;
    tick();

    // lw to GPIO, slave acks one cycle after req_s rises
    req_m  = 1'b1;
    addr_m = 32'h0001_0004;
    we_m   = 1'b0;
    tick();
    chk("t1_req_s_c1", 32'(req_s), 32'h2);
    chk("t1_addr_s", addr_s, 32'h0001_0004);
    chk("t1_we_s", 32'(we_s), 32'h0);
    chk("t1_sel", 32'(slave_sel), 32'h2);
    chk("t1_ack_m_c1", 32'(req_ack_m), 32'h0);
    tick();
    chk("t1_req_s_c2", 32'(req_s), 32'h2);
    chk("t1_ack_m_c2", 32'(req_ack_m), 32'h0);
    req_ack_s = 4'b0010;
    addr_m    = 32'h0002_0000;
    tick();
    chk("t1_ack_m", 32'(req_ack_m), 32'h1);
    chk("t1_err_m", 32'(err_m), 32'h0);
    chk("t1_req_s_drop", 32'(req_s), 32'h0);
    chk("t1_addr_stable", addr_s, 32'h0001_0004);
    req_m     = 1'b0;
    req_ack_s = '0;
    tick();
    chk("t1_ack_pulse", 32'(req_ack_m), 32'h0);

    // sw to UART, immediate ack
    req_m     = 1'b1;
    addr_m    = 32'h0003_0000;
    we_m      = 1'b1;
    wd_m      = 32'hDEAD_BEEF;
    req_ack_s = 4'b1000;
    tick();
    chk("t2_req_s", 32'(req_s), 32'h8);
    chk("t2_we_s", 32'(we_s), 32'h1);
    chk("t2_wd_s", wd_s, 32'hDEAD_BEEF);
    chk("t2_sel", 32'(slave_sel), 32'h8);
    tick();
    chk("t2_ack_m", 32'(req_ack_m), 32'h1);
    chk("t2_err_m", 32'(err_m), 32'h0);
    req_m     = 1'b0;
    req_ack_s = '0;
    we_m      = 1'b0;
    tick();

    // slave1 access, then an unmapped address
    req_m     = 1'b1;
    addr_m    = 32'h0001_0000;
    req_ack_s = 4'b0010;
    tick();
    tick();
    chk("t3_pre_ack", 32'(req_ack_m), 32'h1);
    req_m     = 1'b0;
    req_ack_s = '0;
    tick();
    req_m  = 1'b1;
    addr_m = 32'h0009_0000;
    tick();
    chk("t3_ack_m", 32'(req_ack_m), 32'h1);
    chk("t3_err_m", 32'(err_m), 32'h1);
    chk("t3_req_s", 32'(req_s), 32'h0);
    chk("t3_sel_kept", 32'(slave_sel), 32'h2);
    req_m = 1'b0;
    tick();
    chk("t3_ack_pulse", 32'(req_ack_m), 32'h0);
    chk("t3_err_clr", 32'(err_m), 32'h0);

    // PWM never acks; other slaves' acks must be ignored
    req_m     = 1'b1;
    addr_m    = 32'h0002_0000;
    req_ack_s = 4'b1011;
    tick();
    chk("t4_req_s_1", 32'(req_s), 32'h4);
    for (int i = 2; i <= 15; i++) begin
      tick();
      chk($sformatf("t4_req_s_%0d", i), 32'(req_s), 32'h4);
    end
    chk("t4_no_ack_early", 32'(req_ack_m), 32'h0);
    tick();
    chk("t4_req_s_drop", 32'(req_s), 32'h0);
    chk("t4_ack_m", 32'(req_ack_m), 32'h1);
    chk("t4_err_m", 32'(err_m), 32'h1);
    req_m     = 1'b0;
    req_ack_s = '0;
    tick();

    // PWM acks in the same cycle the limit is reached: ack wins
    req_m  = 1'b1;
    addr_m = 32'h0002_0000;
    tick();
    for (int i = 2; i <= 15; i++) tick();
    chk("t5_req_s_15", 32'(req_s), 32'h4);
    req_ack_s = 4'b0100;
    tick();
    chk("t5_ack_m", 32'(req_ack_m), 32'h1);
    chk("t5_err_m", 32'(err_m), 32'h0);
    req_m     = 1'b0;
    req_ack_s = '0;
    tick();

    // Back-to-back: slave0 then slave3 with req_m held high
    req_m     = 1'b1;
    addr_m    = 32'h0000_0010;
    req_ack_s = 4'b1001;
    tick();
    chk("t6_req_s_a", 32'(req_s), 32'h1);
    chk("t6_sel_a", 32'(slave_sel), 32'h1);
    tick();
    chk("t6_ack_a", 32'(req_ack_m), 32'h1);
    chk("t6_err_a", 32'(err_m), 32'h0);
    addr_m = 32'h0003_0000;
    tick();
    chk("t6_idle_req_s", 32'(req_s), 32'h0);
    chk("t6_idle_sel", 32'(slave_sel), 32'h1);
    tick();
    chk("t6_req_s_b", 32'(req_s), 32'h8);
    chk("t6_sel_b", 32'(slave_sel), 32'h8);
    tick();
    chk("t6_ack_b", 32'(req_ack_m), 32'h1);
    req_m     = 1'b0;
    req_ack_s = '0;
    tick();

    // Reset asserted during WAIT
    req_m  = 1'b1;
    addr_m = 32'h0001_0000;
    tick();
    chk("t7_req_s_wait", 32'(req_s), 32'h2);
    #2;
    resetn = 1'b0;
    req_m  = 1'b0;
    #1;
    chk("t7_async_req_s", 32'(req_s), 32'h0);
    chk("t7_async_sel", 32'(slave_sel), 32'h0);
    chk("t7_async_ack_m", 32'(req_ack_m), 32'h0);
    chk("t7_async_addr_s", addr_s, 32'h0);
    #2;
    resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t7_no_ack_%0d", i), 32'(req_ack_m), 32'h0);
      chk($sformatf("t7_no_req_%0d", i), 32'(req_s), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
